// File: rtl/bus_master_arbiter.sv
// Two-master round-robin arbiter for the shared data bus (dmem + accumulator).
// Define ARB_ERR_EN to enable per-ack unmapped-address flags and err_count.
module bus_master_arbiter #(
    parameter logic [31:0] DMEM_MASK = 32'hFFFFFF80,
    parameter logic [31:0] ACC_MASK  = 32'hFFFFFFF0,
    parameter logic [31:0] ACC_BASE  = 32'h00000200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [3:0]  m0_we,
    input  logic [31:0] m0_wdata,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [3:0]  m1_we,
    input  logic [31:0] m1_wdata,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic [7:0]  err_count,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_we,
    output logic [31:0] bus_wdata,
    output logic        enable1,
    output logic        enable2,
    input  logic [31:0] rdata_dmem,
    input  logic [31:0] rdata_acc
);

    localparam int unsigned DW = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           last_gnt_q;
    logic           owner_q;
    logic           grant;
    logic           gnt_id;
    logic [DW-1:0]  sel_addr;
    logic [3:0]     sel_we;
    logic [DW-1:0]  sel_wdata;
    logic           dmem_hit;
    logic           acc_hit;
    logic [DW-1:0]  rdata_mux;
    logic           unmapped;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state and grant decision; owner's req is ignored in DONE
    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        gnt_id  = 1'b0;
        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    grant   = 1'b1;
                    gnt_id  = (m0_req && m1_req) ? ~last_gnt_q : m1_req;
                    state_d = ACCESS;
                end
            end
            ACCESS: state_d = DONE;
            DONE: begin
                if (owner_q ? m0_req : m1_req) begin
                    grant   = 1'b1;
                    gnt_id  = ~owner_q;
                    state_d = ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sel_addr  = gnt_id ? m1_addr  : m0_addr;
    assign sel_we    = gnt_id ? m1_we    : m0_we;
    assign sel_wdata = gnt_id ? m1_wdata : m0_wdata;

    // Enables are decoded from the address being latched so they line up with ACCESS
    assign dmem_hit  = (sel_addr & DMEM_MASK) == '0;
    assign acc_hit   = (sel_addr & ACC_MASK) == ACC_BASE;

    assign rdata_mux = enable2 ? rdata_acc : (enable1 ? rdata_dmem : '0);
    assign unmapped  = !enable1 && !enable2;

    // Bus registers, enables, acks and read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_q <= 1'b1;
            owner_q    <= 1'b0;
            bus_addr   <= '0;
            bus_we     <= '0;
            bus_wdata  <= '0;
            enable1    <= 1'b0;
            enable2    <= 1'b0;
            m0_ack     <= 1'b0;
            m1_ack     <= 1'b0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
        end else begin
            bus_we   <= '0;
            enable1  <= 1'b0;
            enable2  <= 1'b0;
            m0_ack   <= 1'b0;
            m1_ack   <= 1'b0;
            m0_rdata <= '0;
            m1_rdata <= '0;
            if (grant) begin
                bus_addr   <= sel_addr;
                bus_we     <= sel_we;
                bus_wdata  <= sel_wdata;
                enable1    <= dmem_hit;
                enable2    <= acc_hit;
                owner_q    <= gnt_id;
                last_gnt_q <= gnt_id;
            end
            if (state_q == ACCESS) begin
                if (owner_q) begin
                    m1_ack   <= 1'b1;
                    m1_rdata <= rdata_mux;
                end else begin
                    m0_ack   <= 1'b1;
                    m0_rdata <= rdata_mux;
                end
            end
        end
    end

`ifdef ARB_ERR_EN
    // Unmapped-access flags ride with the ack; counter saturates at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0_err    <= 1'b0;
            m1_err    <= 1'b0;
            err_count <= '0;
        end else begin
            m0_err <= 1'b0;
            m1_err <= 1'b0;
            if (state_q == ACCESS && unmapped) begin
                m0_err <= !owner_q;
                m1_err <= owner_q;
                if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end
        end
    end
`else
    assign m0_err    = 1'b0;
    assign m1_err    = 1'b0;
    assign err_count = 8'h00;
    logic unused_err;
    assign unused_err = unmapped;
`endif

endmodule

// File: tb/tb_bus_master_arbiter.sv
// Directed self-checking bench for bus_master_arbiter (honours ARB_ERR_EN).
module tb_bus_master_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m1_req;
    logic [31:0] m0_addr, m1_addr;
    logic [3:0]  m0_we, m1_we;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_ack, m1_ack;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_err, m1_err;
    logic [7:0]  err_count;
    logic [31:0] bus_addr;
    logic [3:0]  bus_we;
    logic [31:0] bus_wdata;
    logic        enable1, enable2;
    logic [31:0] rdata_dmem, rdata_acc;

    int checks = 0;
    int errors = 0;

`ifdef ARB_ERR_EN
    localparam logic       ERR_ON  = 1'b1;
    localparam logic [7:0] CNT_ONE = 8'h01;
    localparam logic [7:0] CNT_SAT = 8'hFF;
`else
    localparam logic       ERR_ON  = 1'b0;
    localparam logic [7:0] CNT_ONE = 8'h00;
    localparam logic [7:0] CNT_SAT = 8'h00;
`endif

    always #5 clk = ~clk;

    bus_master_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wdata(m0_wdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .err_count(err_count),
        .bus_addr(bus_addr), .bus_we(bus_we), .bus_wdata(bus_wdata),
        .enable1(enable1), .enable2(enable2),
        .rdata_dmem(rdata_dmem), .rdata_acc(rdata_acc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        m0_req = 1'b0; m0_addr = '0; m0_we = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_addr = '0; m1_we = '0; m1_wdata = '0;
        rdata_dmem = 32'hDEADBEEF; rdata_acc = 32'hA5A50000;
        tick(); tick();

        // Reset state
        chk("rst_m0_ack",   32'(m0_ack), 32'd0);
        chk("rst_m1_ack",   32'(m1_ack), 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_we",   32'(bus_we), 32'd0);
        chk("rst_en",       32'({enable1, enable2}), 32'd0);
        chk("rst_err_cnt",  32'(err_count), 32'd0);
        rst_n = 1'b1;
        tick();

        // M0 reads dmem 0x04
        m0_req = 1'b1; m0_addr = 32'h04; m0_we = 4'h0;
        tick();
        chk("rd_enable1",  32'(enable1), 32'd1);
        chk("rd_enable2",  32'(enable2), 32'd0);
        chk("rd_bus_addr", bus_addr, 32'h04);
        chk("rd_ack_early", 32'(m0_ack), 32'd0);
        tick();
        chk("rd_m0_ack",   32'(m0_ack), 32'd1);
        chk("rd_m0_rdata", m0_rdata, 32'hDEADBEEF);
        chk("rd_m0_err",   32'(m0_err), 32'd0);
        chk("rd_m1_ack",   32'(m1_ack), 32'd0);
        chk("rd_en_off",   32'(enable1), 32'd0);
        m0_req = 1'b0;
        tick();
        chk("rd_ack_pulse", 32'(m0_ack), 32'd0);
        chk("rd_rdata_clr", m0_rdata, 32'd0);

        // M1 writes accumulator 0x200
        m1_req = 1'b1; m1_addr = 32'h200; m1_we = 4'hF; m1_wdata = 32'h12345678;
        tick();
        chk("wr_enable2",   32'(enable2), 32'd1);
        chk("wr_enable1",   32'(enable1), 32'd0);
        chk("wr_bus_we",    32'(bus_we), 32'hF);
        chk("wr_bus_wdata", bus_wdata, 32'h12345678);
        tick();
        chk("wr_m1_ack",    32'(m1_ack), 32'd1);
        chk("wr_m1_rdata",  m1_rdata, 32'hA5A50000);
        chk("wr_we_after",  32'(bus_we), 32'd0);
        chk("wr_en2_after", 32'(enable2), 32'd0);
        m1_req = 1'b0; m1_we = 4'h0;
        tick();

        // Tie with last_gnt=1: M0 first, M1 straight from DONE
        rdata_dmem = 32'h00000111; rdata_acc = 32'h00000222;
        m0_req = 1'b1; m0_addr = 32'h08;
        m1_req = 1'b1; m1_addr = 32'h204;
        tick();
        chk("tie1_addr_m0", bus_addr, 32'h08);
        tick();
        chk("tie1_m0_ack",   32'(m0_ack), 32'd1);
        chk("tie1_m0_rdata", m0_rdata, 32'h111);
        chk("tie1_m1_ack",   32'(m1_ack), 32'd0);
        chk("tie1_m1_rdata", m1_rdata, 32'd0);
        m0_req = 1'b0;
        tick();
        chk("tie1_addr_m1",  bus_addr, 32'h204);
        chk("tie1_m1_en2",   32'(enable2), 32'd1);
        tick();
        chk("tie1_m1_ack2",  32'(m1_ack), 32'd1);
        chk("tie1_m1_rd2",   m1_rdata, 32'h222);
        m1_req = 1'b0;
        tick();

        // Single M0 transaction leaves last_gnt=0, so the next tie goes to M1
        m0_req = 1'b1; m0_addr = 32'h10;
        tick(); tick();
        chk("solo_m0_ack", 32'(m0_ack), 32'd1);
        m0_req = 1'b0;
        tick();
        m0_req = 1'b1; m0_addr = 32'h14;
        m1_req = 1'b1; m1_addr = 32'h20C;
        tick();
        chk("tie2_addr_m1", bus_addr, 32'h20C);
        tick();
        chk("tie2_m1_ack", 32'(m1_ack), 32'd1);
        chk("tie2_m0_ack", 32'(m0_ack), 32'd0);
        m1_req = 1'b0;
        tick();
        chk("tie2_addr_m0", bus_addr, 32'h14);
        tick();
        chk("tie2_m0_ack2", 32'(m0_ack), 32'd1);
        m0_req = 1'b0;
        tick();

        // Unmapped read at 0x100
        rdata_dmem = 32'hCAFEF00D; rdata_acc = 32'h0BADBEEF;
        m0_req = 1'b1; m0_addr = 32'h100;
        tick();
        chk("um_enables", 32'({enable1, enable2}), 32'd0);
        tick();
        chk("um_m0_ack",   32'(m0_ack), 32'd1);
        chk("um_m0_rdata", m0_rdata, 32'd0);
        chk("um_m0_err",   32'(m0_err), 32'(ERR_ON));
        chk("um_m1_err",   32'(m1_err), 32'd0);
        chk("um_err_cnt",  32'(err_count), 32'(CNT_ONE));
        m0_req = 1'b0;
        tick();
        chk("um_err_pulse", 32'(m0_err), 32'd0);

        // 300 more unmapped reads saturate the counter
        for (int i = 0; i < 300; i++) begin
            m0_req = 1'b1;
            tick(); tick();
            m0_req = 1'b0;
            tick();
        end
        chk("um_err_sat", 32'(err_count), 32'(CNT_SAT));

        // Reset asserted mid-ACCESS of an M1 write
        m1_req = 1'b1; m1_addr = 32'h00; m1_we = 4'hF; m1_wdata = 32'h55AA55AA;
        tick();
        chk("mid_en1", 32'(enable1), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_en_clr",   32'({enable1, enable2}), 32'd0);
        chk("mid_we_clr",   32'(bus_we), 32'd0);
        chk("mid_addr_clr", bus_addr, 32'd0);
        chk("mid_cnt_clr",  32'(err_count), 32'd0);
        tick();
        chk("mid_no_ack",   32'(m1_ack), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("re_en1",    32'(enable1), 32'd1);
        chk("re_we",     32'(bus_we), 32'hF);
        chk("re_no_ack", 32'(m1_ack), 32'd0);
        tick();
        chk("re_m1_ack", 32'(m1_ack), 32'd1);
        m1_req = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
